serial_subtractor: RTL

// - Bit-serial N-bit subtractor: diff = a - b - B_in, computed LSB-first, one bit per clock.
// - One combinational full-subtractor cell (diff/borrow) is reused over N cycles. Borrow is

---
 rtl/serial_sub_pkg.sv | 21 ++
 rtl/serial_subtractor_if.sv | 31 +++
 rtl/full_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 113 +++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared types and helpers for the bit-serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter must hold 0..N-1 and is never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Operand/result valid-ready bundle of the serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int N = 4
);
    logic         start_valid;
    logic         start_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         B_in;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] diff;
    logic         B_out;
    logic         busy;

    modport master (
        output start_valid, a, b, B_in, res_ready,
        input  start_ready, res_valid, diff, B_out, busy
    );

    modport slave (
        input  start_valid, a, b, B_in, res_ready,
        output start_ready, res_valid, diff, B_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : One-bit full-subtractor cell: diff = a - b - B_in.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  wire logic B_in,
    input  wire logic a,
    input  wire logic b,
    output logic      diff,
    output logic      B_out
);
    assign diff  = a ^ b ^ B_in;
    assign B_out = (~a & b) | (~(a ^ b) & B_in);
endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : LSB-first bit-serial N-bit subtractor, one bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_subtractor_if.slave bus
);
    localparam int             CNT_W    = cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     a_sh_q, a_sh_d;
    logic [N-1:0]     b_sh_q, b_sh_d;
    logic [N-1:0]     res_sh_q, res_sh_d;
    logic [N-1:0]     diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             cell_diff;
    logic             cell_borrow;
    logic [N-1:0]     fill_msb;

    full_subtractor u_cell (
        .B_in  (borrow_q),
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .diff  (cell_diff),
        .B_out (cell_borrow)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;
        fill_msb = '0;
        fill_msb[N-1] = cell_diff;

        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    borrow_d = bus.B_in;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = (res_sh_q >> 1) | fill_msb;
                borrow_d = cell_borrow;
                cnt_d    = cnt_q + 1'b1;
                // The visible result only updates here, so it stays put while a new operation shifts.
                if (cnt_q == CNT_LAST) begin
                    diff_d  = res_sh_d;
                    bout_d  = cell_borrow;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.res_valid   = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.diff        = diff_q;
    assign bus.B_out       = bout_q;

endmodule
`default_nettype wire
